pwm_ramp_ctrl: RTL and testbench

//  Sequences the 8-bit duty_cycle input of the PWM generator for one motor channel.
//  - Accepts target-duty commands over a valid/ready handshake.
//  - Slews the applied duty toward the target at a programmed rate (soft start and soft stop).
//  - Forces duty to 0 on the IR obstacle input, then holds off before re-arming.
//  - Sits between the command/decision logic and the PWM generator; duty_out drives the generator's duty_cycle.

---
 rtl/pwm_ctrl_pkg.sv | 19 +
 rtl/ramp_tick_gen.sv | 27 ++
 rtl/pwm_ramp_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types for the PWM duty ramp controller.
// Holds the FSM state encoding, the duty width and a ramp-state helper.
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_e;

  function automatic logic is_ramp(input state_e s);
    return (s == RAMP_UP) || (s == RAMP_DOWN);
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: counts 0..RAMP_DIV-1 and pulses tick for one cycle on wrap.
// Latency: first tick RAMP_DIV cycles after clear drops; clear holds the count at 0.
// Backpressure: none, free-running whenever clear is low.
module ramp_tick_gen #(
  parameter int RAMP_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = ~clear & (cnt == CW'(RAMP_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty slew controller for one motor channel; optional cmd watchdog via PWM_RAMP_CMD_TIMEOUT_EN.
// Latency: duty_out registered, one step of STEP every RAMP_DIV cycles while ramping; ir forces 0 next edge.
// Backpressure: cmd_ready = enable & ~ir & not FAULT, combinational, independent of cmd_valid.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int RAMP_DIV    = 1000,
  parameter int STEP        = 4,
  parameter int IR_HOLDOFF  = 50000,
  parameter int CMD_TIMEOUT = 2**20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              ir,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              cmd_ready,
  output logic [DUTY_W-1:0] duty_out,
  output logic [2:0]        state_out,
  output logic              busy,
  output logic              fault
);

  localparam int HW = $clog2(IR_HOLDOFF + 1);

  if (RAMP_DIV < 1 || STEP < 1 || STEP > 255 || IR_HOLDOFF < 1 || CMD_TIMEOUT < 1) begin : g_param_chk
    $error("pwm_ramp_ctrl: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              tick;
  logic              accept;
  logic              wd_expired;
  logic              wd_to;

  ramp_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (~is_ramp(state_q)),
    .tick  (tick)
  );

  assign cmd_ready = enable & ~ir & (state_q != FAULT);
  assign accept    = cmd_valid & cmd_ready;

`ifdef PWM_RAMP_CMD_TIMEOUT_EN
  localparam int WW = $clog2(CMD_TIMEOUT + 1);

  logic [WW-1:0] wd_q;

  assign wd_expired = (wd_q == WW'(CMD_TIMEOUT));

  // Saturates at CMD_TIMEOUT so the expiry stays visible until a cmd or IDLE/FAULT clears it.
  always_ff @(posedge clk) begin
    if (rst || accept || state_q == IDLE || state_q == FAULT) begin
      wd_q <= '0;
    end else if (!wd_expired) begin
      wd_q <= wd_q + WW'(1);
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  assign wd_to = wd_expired & ~accept & ((state_q == RUN) || (state_q == RAMP_UP));

  logic [DUTY_W:0]        up_sum;
  logic [DUTY_W-1:0]      up_val;
  logic [DUTY_W-1:0]      dn_tgt;
  logic signed [DUTY_W:0] dn_diff;
  logic [DUTY_W-1:0]      dn_val;

  assign up_sum  = {1'b0, duty_q} + (DUTY_W+1)'(STEP);
  assign up_val  = (up_sum > {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
  assign dn_tgt  = enable ? target_q : '0;
  assign dn_diff = $signed({1'b0, duty_q}) - $signed((DUTY_W+1)'(STEP));
  assign dn_val  = (dn_diff < $signed({1'b0, dn_tgt})) ? dn_tgt : dn_diff[DUTY_W-1:0];

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    hold_d   = '0;

    if (ir) begin
      state_d  = FAULT;
      duty_d   = '0;
      target_d = '0;
    end else if (state_q == FAULT) begin
      duty_d   = '0;
      target_d = '0;
      if (hold_q == HW'(IR_HOLDOFF - 1)) begin
        state_d = IDLE;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end else begin
      if (!enable || wd_to) begin
        target_d = '0;
      end else if (accept) begin
        target_d = cmd_duty;
      end

      // FSM decisions use the registered target; a freshly accepted cmd acts next cycle.
      case (state_q)
        IDLE: begin
          duty_d = '0;
          if (accept && cmd_duty != '0) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (!enable || wd_to) begin
            state_d = (duty_q == '0) ? IDLE : RAMP_DOWN;
          end else if (target_q < duty_q) begin
            state_d = RAMP_DOWN;
          end else if (target_q == duty_q) begin
            state_d = (target_q == '0) ? IDLE : RUN;
          end else if (tick) begin
            duty_d = up_val;
            if (up_val == target_q) state_d = RUN;
          end
        end
        RUN: begin
          if (!enable || wd_to) begin
            state_d = (duty_q == '0) ? IDLE : RAMP_DOWN;
          end else if (target_q > duty_q) begin
            state_d = RAMP_UP;
          end else if (target_q < duty_q) begin
            state_d = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (dn_tgt > duty_q) begin
            state_d = RAMP_UP;
          end else if (dn_tgt == duty_q) begin
            state_d = (dn_tgt == '0) ? IDLE : RUN;
          end else if (tick) begin
            duty_d = dn_val;
            if (dn_val == dn_tgt) state_d = (dn_tgt == '0) ? IDLE : RUN;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      hold_q   <= hold_d;
    end
  end

  assign duty_out  = duty_q;
  assign state_out = state_q;
  assign busy      = is_ramp(state_q);
  assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed-vector bench for pwm_ramp_ctrl: instance a uses STEP=4, instance b uses STEP=100.
module tb_pwm_ramp_ctrl;
  import pwm_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, enable, ir, cmd_valid;
  logic [7:0] cmd_duty;
  logic       rdy_a, busy_a, fault_a, rdy_b, busy_b, fault_b;
  logic [7:0] duty_a, duty_b;
  logic [2:0] st_a, st_b;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.RAMP_DIV(4), .STEP(4), .IR_HOLDOFF(8), .CMD_TIMEOUT(32)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .ir(ir), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty),
    .cmd_ready(rdy_a), .duty_out(duty_a), .state_out(st_a), .busy(busy_a), .fault(fault_a)
  );

  pwm_ramp_ctrl #(.RAMP_DIV(4), .STEP(100), .IR_HOLDOFF(8), .CMD_TIMEOUT(4096)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .ir(ir), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty),
    .cmd_ready(rdy_b), .duty_out(duty_b), .state_out(st_b), .busy(busy_b), .fault(fault_b)
  );

  typedef struct {
    string      name;
    logic       rst, en, ir, cv;
    logic [7:0] cd;
    int         n;
    logic       exp_rdy;
    logic [7:0] exp_duty;
    logic [2:0] exp_st;
  } vec_t;

  vec_t tbl[$];
  vec_t seq_b[$];
  vec_t seq_t[$];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(string name, logic r, logic e, logic i, logic c, logic [7:0] d,
                              int n, logic rd, logic [7:0] du, logic [2:0] s);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.ir = i; v.cv = c; v.cd = d; v.n = n;
    v.exp_rdy = rd; v.exp_duty = du; v.exp_st = s;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs change on the falling edge, are held for n rising edges, outputs sampled 1ns later.
  task automatic run(input vec_t v, input bit use_b);
    logic exp_busy, exp_fault;
    @(negedge clk);
    rst = v.rst; enable = v.en; ir = v.ir; cmd_valid = v.cv; cmd_duty = v.cd;
    repeat (v.n) @(posedge clk);
    #1;
    exp_busy  = (v.exp_st == 3'd1) || (v.exp_st == 3'd3);
    exp_fault = (v.exp_st == 3'd4);
    chk({v.name, ".ready"}, use_b ? rdy_b  : rdy_a,  v.exp_rdy);
    chk({v.name, ".duty"},  use_b ? duty_b : duty_a, v.exp_duty);
    chk({v.name, ".state"}, use_b ? st_b   : st_a,   v.exp_st);
    chk({v.name, ".busy"},  use_b ? busy_b : busy_a, exp_busy);
    chk({v.name, ".fault"}, use_b ? fault_b: fault_a, exp_fault);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; ir = 1'b0; cmd_valid = 1'b0; cmd_duty = 8'd0;

    //                name        rst en ir cv cd   n   rdy duty state
    tbl.push_back(mk("rst",       1, 1, 0, 0, 0,   2,  1, 0,   IDLE));
    tbl.push_back(mk("acc20",     0, 1, 0, 1, 20,  1,  1, 0,   RAMP_UP));
    tbl.push_back(mk("up4",       0, 1, 0, 0, 0,   4,  1, 4,   RAMP_UP));
    tbl.push_back(mk("up8_wait",  0, 1, 0, 0, 0,   3,  1, 4,   RAMP_UP));
    tbl.push_back(mk("up8",       0, 1, 0, 0, 0,   1,  1, 8,   RAMP_UP));
    tbl.push_back(mk("up12",      0, 1, 0, 0, 0,   4,  1, 12,  RAMP_UP));
    tbl.push_back(mk("up16",      0, 1, 0, 0, 0,   4,  1, 16,  RAMP_UP));
    tbl.push_back(mk("run20",     0, 1, 0, 0, 0,   4,  1, 20,  RUN));
    tbl.push_back(mk("acc6",      0, 1, 0, 1, 6,   1,  1, 20,  RUN));
    tbl.push_back(mk("dn_go",     0, 1, 0, 0, 0,   1,  1, 20,  RAMP_DOWN));
    tbl.push_back(mk("dn16",      0, 1, 0, 0, 0,   4,  1, 16,  RAMP_DOWN));
    tbl.push_back(mk("dn12",      0, 1, 0, 0, 0,   4,  1, 12,  RAMP_DOWN));
    tbl.push_back(mk("dn8",       0, 1, 0, 0, 0,   4,  1, 8,   RAMP_DOWN));
    tbl.push_back(mk("dn6_clamp", 0, 1, 0, 0, 0,   4,  1, 6,   RUN));
    tbl.push_back(mk("acc30",     0, 1, 0, 1, 30,  1,  1, 6,   RUN));
    tbl.push_back(mk("up_go",     0, 1, 0, 0, 0,   1,  1, 6,   RAMP_UP));
    tbl.push_back(mk("up10",      0, 1, 0, 0, 0,   4,  1, 10,  RAMP_UP));
    tbl.push_back(mk("mid",       0, 1, 0, 0, 0,   3,  1, 10,  RAMP_UP));
    tbl.push_back(mk("ir_on_tick",0, 1, 1, 0, 0,   1,  0, 0,   FAULT));
    tbl.push_back(mk("hold3",     0, 1, 0, 1, 50,  3,  0, 0,   FAULT));
    tbl.push_back(mk("ir_glitch", 0, 1, 1, 0, 0,   1,  0, 0,   FAULT));
    tbl.push_back(mk("hold7",     0, 1, 0, 0, 0,   7,  0, 0,   FAULT));
    tbl.push_back(mk("rearm",     0, 1, 0, 0, 0,   1,  1, 0,   IDLE));
    tbl.push_back(mk("ir_vs_cmd", 0, 1, 1, 1, 50,  1,  0, 0,   FAULT));
    tbl.push_back(mk("clear8",    0, 1, 0, 0, 0,   8,  1, 0,   IDLE));
    tbl.push_back(mk("acc12",     0, 1, 0, 1, 12,  1,  1, 0,   RAMP_UP));
    tbl.push_back(mk("run12",     0, 1, 0, 0, 0,   12, 1, 12,  RUN));
    tbl.push_back(mk("en_off",    0, 0, 0, 0, 0,   1,  0, 12,  RAMP_DOWN));
    tbl.push_back(mk("off8",      0, 0, 0, 0, 0,   4,  0, 8,   RAMP_DOWN));
    tbl.push_back(mk("off4",      0, 0, 0, 0, 0,   4,  0, 4,   RAMP_DOWN));
    tbl.push_back(mk("off0",      0, 0, 0, 1, 40,  4,  0, 0,   IDLE));
    tbl.push_back(mk("off_cmd",   0, 0, 0, 1, 40,  2,  0, 0,   IDLE));
    tbl.push_back(mk("en_on",     0, 1, 0, 0, 0,   5,  1, 0,   IDLE));
    tbl.push_back(mk("acc8",      0, 1, 0, 1, 8,   1,  1, 0,   RAMP_UP));
    tbl.push_back(mk("run8",      0, 1, 0, 0, 0,   8,  1, 8,   RUN));
    tbl.push_back(mk("zero_cmd",  0, 1, 0, 1, 0,   1,  1, 8,   RUN));
    tbl.push_back(mk("z_go",      0, 1, 0, 0, 0,   1,  1, 8,   RAMP_DOWN));
    tbl.push_back(mk("z4",        0, 1, 0, 0, 0,   4,  1, 4,   RAMP_DOWN));
    tbl.push_back(mk("z0",        0, 1, 0, 0, 0,   4,  1, 0,   IDLE));
    tbl.push_back(mk("acc16",     0, 1, 0, 1, 16,  1,  1, 0,   RAMP_UP));
    tbl.push_back(mk("rt8",       0, 1, 0, 0, 0,   8,  1, 8,   RAMP_UP));
    tbl.push_back(mk("rt_cmd4",   0, 1, 0, 1, 4,   1,  1, 8,   RAMP_UP));
    tbl.push_back(mk("rt_dir",    0, 1, 0, 0, 0,   1,  1, 8,   RAMP_DOWN));
    tbl.push_back(mk("rt4",       0, 1, 0, 0, 0,   2,  1, 4,   RUN));
    tbl.push_back(mk("rt_off",    0, 0, 0, 0, 0,   1,  0, 4,   RAMP_DOWN));
    tbl.push_back(mk("rt_off0",   0, 0, 0, 0, 0,   4,  0, 0,   IDLE));
    tbl.push_back(mk("acc40",     0, 1, 0, 1, 40,  1,  1, 0,   RAMP_UP));
    tbl.push_back(mk("r_up4",     0, 1, 0, 0, 0,   5,  1, 4,   RAMP_UP));
    tbl.push_back(mk("rst_mid",   1, 1, 0, 0, 0,   1,  1, 0,   IDLE));
    tbl.push_back(mk("post_rst",  0, 1, 0, 0, 0,   6,  1, 0,   IDLE));

    seq_b.push_back(mk("b_rst",   1, 1, 0, 0, 0,   2,  1, 0,   IDLE));
    seq_b.push_back(mk("b_acc",   0, 1, 0, 1, 254, 1,  1, 0,   RAMP_UP));
    seq_b.push_back(mk("b100",    0, 1, 0, 0, 0,   4,  1, 100, RAMP_UP));
    seq_b.push_back(mk("b200",    0, 1, 0, 0, 0,   4,  1, 200, RAMP_UP));
    seq_b.push_back(mk("b254",    0, 1, 0, 0, 0,   4,  1, 254, RUN));
    seq_b.push_back(mk("b_zero",  0, 1, 0, 1, 0,   1,  1, 254, RUN));
    seq_b.push_back(mk("b_go",    0, 1, 0, 0, 0,   1,  1, 254, RAMP_DOWN));
    seq_b.push_back(mk("b154",    0, 1, 0, 0, 0,   4,  1, 154, RAMP_DOWN));
    seq_b.push_back(mk("b54",     0, 1, 0, 0, 0,   4,  1, 54,  RAMP_DOWN));
    seq_b.push_back(mk("b0",      0, 1, 0, 0, 0,   4,  1, 0,   IDLE));

    seq_t.push_back(mk("t_rst",   1, 1, 0, 0, 0,   2,  1, 0,   IDLE));
    seq_t.push_back(mk("t_acc",   0, 1, 0, 1, 8,   1,  1, 0,   RAMP_UP));
    seq_t.push_back(mk("t_run",   0, 1, 0, 0, 0,   8,  1, 8,   RUN));
`ifdef PWM_RAMP_CMD_TIMEOUT_EN
    seq_t.push_back(mk("t_wait",  0, 1, 0, 0, 0,   24, 1, 8,   RUN));
    seq_t.push_back(mk("t_fire",  0, 1, 0, 0, 0,   1,  1, 8,   RAMP_DOWN));
    seq_t.push_back(mk("t4",      0, 1, 0, 0, 0,   4,  1, 4,   RAMP_DOWN));
    seq_t.push_back(mk("t0",      0, 1, 0, 0, 0,   4,  1, 0,   IDLE));
    seq_t.push_back(mk("t_acc2",  0, 1, 0, 1, 8,   1,  1, 0,   RAMP_UP));
    seq_t.push_back(mk("t_up4",   0, 1, 0, 0, 0,   5,  1, 4,   RAMP_UP));
    seq_t.push_back(mk("t_rst2",  1, 1, 0, 0, 0,   1,  1, 0,   IDLE));
    seq_t.push_back(mk("t_idle",  0, 1, 0, 0, 0,   4,  1, 0,   IDLE));
`else
    seq_t.push_back(mk("t_hold",  0, 1, 0, 0, 0,   100, 1, 8,  RUN));
`endif

    foreach (tbl[i])   run(tbl[i], 1'b0);
    foreach (seq_b[i]) run(seq_b[i], 1'b1);
    foreach (seq_t[i]) run(seq_t[i], 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
